// File: rtl/pipe_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_pkg : shared MEM-stage types and alignment constants         |
// | Rev 1.0  : initial release                                        |
// +------------------------------------------------------------------+
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int         WORD_BYTES = 4;
  localparam logic [1:0] ALIGN_MASK = 2'(WORD_BYTES - 1);

  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) == 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_counter : up-counter with synchronous clear, holds at all-ones|
// | Rev 1.0     : initial release                                     |
// +------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (en && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_access_ctrl : MEM-stage load/store sequencer over req/ack port|
// | Rev 1.0         : initial release                                 |
// +------------------------------------------------------------------+
module mem_access_ctrl
  import pipe_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] read_data,
  output logic              wb_valid,
  output logic              misalign_err,
  output logic              timeout_err,
  output logic [31:0]       stall_count
);

  localparam int         WAIT_W    = 16;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  mem_state_t        r_state;
  mem_state_t        w_next;
  logic              r_kill;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_read_data;
  logic              r_misalign;
  logic              r_timeout;
  logic              w_acc;
  logic              w_aligned;
  logic              w_busy;
  logic              w_timeout;
  logic              w_stall;
  logic              w_wb;
  logic [WAIT_W-1:0] w_wait;

  assign w_acc     = valid_in & (mem_read | mem_write) & ~flush;
  assign w_aligned = is_aligned(addr[1:0]);
  assign w_busy    = (r_state == BUSY);
  // w_wait counts completed BUSY cycles, so this is the TIMEOUT-th one
  assign w_timeout = w_busy && (w_wait == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_wb    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_acc && w_aligned) begin
          w_stall = 1'b1;
          w_next  = BUSY;
        end else if (!w_acc) begin
          w_wb = valid_in & ~flush;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (mem_ack || w_timeout) begin
          w_next = RESP;
        end
      end
      RESP: begin
        w_wb   = ~r_kill & ~flush;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kill      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_read_data <= '0;
      r_misalign  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_misalign <= (r_state == IDLE) && w_acc && !w_aligned;
      r_timeout  <= w_timeout && !mem_ack;
      case (r_state)
        IDLE: begin
          if (w_acc && w_aligned) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= mem_write;
            r_mem_addr  <= addr;
            r_mem_wdata <= wdata;
            r_kill      <= 1'b0;
          end
        end
        BUSY: begin
          // a flushed access still completes on the bus; only commit is blocked
          if (flush) begin
            r_kill <= 1'b1;
          end
          if (mem_ack) begin
            r_mem_req   <= 1'b0;
            r_read_data <= r_mem_we ? '0 : mem_rdata;
          end else if (w_timeout) begin
            r_mem_req   <= 1'b0;
            r_read_data <= '0;
            r_kill      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst | ~w_busy),
    .en    (w_busy),
    .count (w_wait)
  );

  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall),
    .count (stall_count)
  );

  assign stall        = w_stall & ~rst;
  assign wb_valid     = w_wb & ~rst;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign read_data    = r_read_data;
  assign misalign_err = r_misalign;
  assign timeout_err  = r_timeout;

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage of the 5-stage pipeline.
- Accepts a load/store from the EX/MEM register and drives a multi-cycle req/ack memory port.
- Freezes the upstream pipeline while the access is in flight.
- Presents the load data and a write-back qualifier to the MEM/WB register, with misalignment and timeout detection plus a stall-cycle counter.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, max wait cycles for mem_ack before abort (1..2^16-1).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  EX/MEM slot holds a live instruction
- mem_read  in  1  load
- mem_write  in  1  store
- flush  in  1  kill current MEM-stage instruction (branch/exception)
- addr  in  ADDR_W  effective address (alu_result)
- wdata  in  DATA_W  store data
- mem_req  out  1  memory request
- mem_we  out  1  request is a write
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  request write data
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; hold MEM/WB
- read_data  out  DATA_W  load result to MEM/WB read_data
- wb_valid  out  1  MEM/WB may commit this slot
- misalign_err  out  1  one-cycle pulse, unaligned access rejected
- timeout_err  out  1  one-cycle pulse, access aborted
- stall_count  out  32  saturating count of cycles with stall=1

Behaviour:
- Decided: single clock clk; reset rst is synchronous and active-high.
- acc = valid_in & (mem_read | mem_write) & ~flush. mem_read & mem_write together is treated as a write.
- States: IDLE, BUSY, RESP.
- IDLE, no acc:
  - stall=0, no request.
  - wb_valid = valid_in & ~flush (combinational pass-through).
- IDLE, acc with addr[1:0]!=0:
  - No request; misalign_err=1 next cycle.
  - wb_valid=0, stall=0; stay IDLE.
- IDLE, acc aligned:
  - stall=1 combinationally this cycle.
  - Register addr, wdata, we; go to BUSY with mem_req=1 from the next cycle.
- BUSY:
  - stall=1. mem_req/we/addr/wdata are held stable until ack.
  - A wait counter increments each cycle.
  - mem_ack=1: latch mem_rdata into read_data (writes latch 0), drop mem_req next cycle, go to RESP.
  - Counter == TIMEOUT with no ack: drop mem_req, read_data=0, timeout_err pulse, go to RESP with the slot killed.
- RESP, exactly one cycle:
  - stall=0.
  - wb_valid=1 unless the slot was killed.
  - The pipeline advances; go to IDLE.
- Latency: a zero-wait memory (ack in the first mem_req cycle) gives 2 stall cycles per access. Each extra wait cycle adds 1.
- flush:
  - In IDLE, suppresses issue.
  - In BUSY, the bus transaction is not abandoned; a sticky kill bit is set, ack is still awaited, and wb_valid=0 in RESP.
  - In RESP, forces wb_valid=0.
- mem_ack outside BUSY is ignored.
- stall_count increments when stall=1 and saturates at 0xFFFF_FFFF.
- Reset:
  - State to IDLE; all outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, read_data, wb_valid, stall, both error pulses, stall_count).
  - Kill bit and wait counter cleared.
  - Reset during BUSY drops mem_req at that edge; a late ack is ignored.
- read_data holds its value outside RESP until the next completion.

Decomposition:
- Shared package pipe_pkg: state enum mem_state_t {IDLE, BUSY, RESP}, ALIGN_MASK constant, WORD_BYTES=4.
- One sub-module: sat_counter (width param, en, rst, saturating), used for stall_count and the wait counter.

Test Plan:
- Aligned load, addr=0x100, ack on 3rd req cycle with rdata=0xDEADBEEF -> stall high 4 cycles, mem_req high 3 cycles; RESP: read_data=0xDEADBEEF, wb_valid=1; stall_count=4.
- Store addr=0x200, wdata=0x12345678, ack in 1st cycle -> mem_we=1 with stable addr/wdata during req, 2 stall cycles, wb_valid=1, read_data=0.
- Load addr=0x103 -> no mem_req, misalign_err pulse one cycle, stall=0, wb_valid=0.
- TIMEOUT=4, no ack -> mem_req drops after 4 BUSY cycles, timeout_err pulse, wb_valid=0 in RESP, FSM back to IDLE.
- Flush asserted in the 2nd BUSY cycle, ack 2 cycles later -> mem_req held until ack, RESP wb_valid=0.
- Reset asserted mid-BUSY, then late ack -> next cycle mem_req=0, stall=0, stall_count=0; ack causes no response.
- Back-to-back loads -> the second request starts the cycle after RESP; ALU op between accesses gives wb_valid=1 with no stall.
